// File: rtl/seq_serializer.sv
// ============================================================================
// seq_serializer : MSB-first parallel-to-serial front end; SER_PARITY_EN adds
//                  an even-parity bit after each word.   Revision 1.0
// ============================================================================
`default_nettype none

module seq_serializer #(
  parameter int WIDTH      = 8,
  parameter int GAP        = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             seq_out,
  output logic             seq_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_PAR   = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  localparam logic [CW-1:0] c_BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] c_GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             out_q, out_d;
  logic             valid_q, valid_d;
  logic             w_last;
  logic             w_accept;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  assign w_last = (state_q == c_SHIFT) && (cnt_q == c_BIT_LAST);

  // Ready opens in the final serial cycle only when no gap follows the word.
`ifdef SER_PARITY_EN
  assign din_ready = (state_q == c_IDLE) || ((GAP == 0) && (state_q == c_PAR));
`else
  assign din_ready = (state_q == c_IDLE) || ((GAP == 0) && w_last);
`endif

  assign w_accept  = din_valid && din_ready;
  assign seq_out   = out_q;
  assign seq_valid = valid_q;
  assign busy      = (state_q != c_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    sreg_d  = sreg_q;
    out_d   = out_q;
    valid_d = valid_q;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      c_SHIFT: begin
        if (!w_last) begin
          cnt_d   = cnt_q + CW'(1);
          sreg_d  = sreg_q << 1;
          out_d   = sreg_q[WIDTH-2];
          valid_d = 1'b1;
        end
`ifdef SER_PARITY_EN
        else begin
          state_d = c_PAR;
          out_d   = par_q;
          valid_d = 1'b1;
        end
`else
        else if (w_accept) begin
          state_d = c_SHIFT;
          sreg_d  = din;
          cnt_d   = '0;
          out_d   = din[WIDTH-1];
          valid_d = 1'b1;
        end else begin
          state_d = (GAP > 0) ? c_GAP : c_IDLE;
          gcnt_d  = '0;
          out_d   = IDLE_LEVEL;
          valid_d = 1'b0;
        end
`endif
      end
      c_PAR: begin
        if (w_accept) begin
          state_d = c_SHIFT;
          sreg_d  = din;
          cnt_d   = '0;
          out_d   = din[WIDTH-1];
          valid_d = 1'b1;
`ifdef SER_PARITY_EN
          par_d   = ^din;
`endif
        end else begin
          state_d = (GAP > 0) ? c_GAP : c_IDLE;
          gcnt_d  = '0;
          out_d   = IDLE_LEVEL;
          valid_d = 1'b0;
        end
      end
      c_GAP: begin
        out_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        if (gcnt_q == c_GAP_LAST) state_d = c_IDLE;
        else                      gcnt_d  = gcnt_q + GW'(1);
      end
      default: begin
        out_d   = IDLE_LEVEL;
        valid_d = 1'b0;
        cnt_d   = '0;
        if (w_accept) begin
          state_d = c_SHIFT;
          sreg_d  = din;
          out_d   = din[WIDTH-1];
          valid_d = 1'b1;
`ifdef SER_PARITY_EN
          par_d   = ^din;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= c_IDLE;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sreg_q  <= '0;
      out_q   <= IDLE_LEVEL;
      valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      sreg_q  <= sreg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

`default_nettype wire
